// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle joining adjacent pipeline stages.
// The producer uses the master modport; the consumer uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Every output is a flop: head register, valid, ready and occupancy.
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_reg_if.slave         in_bus,
  pipe_stage_reg_if.master        out_bus,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_head_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_occ;
  logic              w_acc;
  logic              w_pop;

  assign w_acc = in_bus.valid && r_in_ready;
  assign w_pop = r_out_valid && out_bus.ready;

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_head_nxt  = in_bus.data;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_pop) begin
          w_head_nxt = in_bus.data;
        end else if (w_acc) begin
          w_skid_nxt  = in_bus.data;
          w_state_nxt = FULL;
        end else if (w_pop) begin
          w_head_nxt  = BUBBLE_VAL;
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_head_nxt  = r_skid;
          w_skid_nxt  = BUBBLE_VAL;
          w_state_nxt = ONE;
        end
      end
      default: begin
        w_head_nxt  = BUBBLE_VAL;
        w_skid_nxt  = BUBBLE_VAL;
        w_state_nxt = EMPTY;
      end
    endcase
    // Flush wins over any accept; a same-cycle pop was already sampled downstream.
    if (flush) begin
      w_head_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
      w_state_nxt = EMPTY;
    end
  end

  // Status outputs are registered copies decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_head      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_occ       <= w_state_nxt;
    end
  end

  assign in_bus.ready  = r_in_ready;
  assign out_bus.valid = r_out_valid;
  assign out_bus.data  = r_head;
  assign occupancy     = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted beats queue up, delivered beats
// are compared against the queue head, status outputs against the queue depth.
module tb_pipe_stage_reg;

  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [1:0]    occ;
  logic [DW-1:0] sb[$];
  int            n_chk;
  int            n_fail;

  pipe_stage_reg_if #(.DATA_W(DW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_if ();

  pipe_stage_reg #(
    .DATA_W    (DW),
    .BUBBLE_VAL(64'h0000_0000_0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_bus   (up_if),
    .out_bus  (dn_if),
    .occupancy(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    flush       = f;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag, input bit do_chk);
    bit acc;
    bit pop;
    int n;
    logic [DW-1:0] exp_data;
    n = sb.size();
    exp_data = (n > 0) ? sb[0] : '0;
    if (do_chk) begin
      chk({tag, "/valid"}, DW'(dn_if.valid), DW'(n != 0));
      chk({tag, "/data"},  dn_if.data, exp_data);
      chk({tag, "/ready"}, DW'(up_if.ready), DW'(n < 2));
      chk({tag, "/occ"},   DW'(occ), DW'(n));
    end
    acc = up_if.valid && (n < 2);
    pop = (n > 0) && dn_if.ready;
    @(posedge clk);
    if (!reset) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (acc) sb.push_back(up_if.data);
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0);
    @(negedge clk);

    // T1: reset held for two edges with a live offer
    step("t1", 1'b0);
    step("t1", 1'b0);
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step("t1_post", 1'b1);

    // T2: streaming at one beat per cycle
    for (int unsigned i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      step("t2", 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step("t2_tail", 1'b1);
    step("t2_drain", 1'b1);

    // T3: fill the skid, offer a third beat while full, then drain
    drive(1'b1, 64'hA1, 1'b0, 1'b0); step("t3_a1", 1'b1);
    drive(1'b1, 64'hA2, 1'b0, 1'b0); step("t3_a2", 1'b1);
    drive(1'b1, 64'hA3, 1'b0, 1'b0); step("t3_full", 1'b1);
    step("t3_hold", 1'b1);
    drive(1'b1, 64'hA3, 1'b1, 1'b0); step("t3_pop1", 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step("t3_drain", 1'b1);

    // T4: flush while full with a concurrent offer
    drive(1'b1, 64'hA1, 1'b0, 1'b0); step("t4_a1", 1'b1);
    drive(1'b1, 64'hA2, 1'b0, 1'b0); step("t4_a2", 1'b1);
    drive(1'b1, 64'hA3, 1'b0, 1'b1); step("t4_flush", 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("t4_after", 1'b1);
    step("t4_idle", 1'b1);

    // T5: flush coinciding with a pop from ONE
    drive(1'b1, 64'h55, 1'b0, 1'b0); step("t5_load", 1'b1);
    drive(1'b0, '0, 1'b1, 1'b1); step("t5_flushpop", 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0); step("t5_after", 1'b1);

    // T6: reset from FULL, then random traffic with occasional flushes
    drive(1'b1, 64'hB1, 1'b0, 1'b0); step("t6_b1", 1'b1);
    drive(1'b1, 64'hB2, 1'b0, 1'b0); step("t6_b2", 1'b1);
    reset = 1'b0;
    drive(1'b1, 64'hB3, 1'b1, 1'b0); step("t6_rst", 1'b1);
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0); step("t6_post", 1'b1);
    for (int unsigned i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      step("t6_rand", 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step("t6_drain", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
